sdram_port_scheduler: RTL and testbench

// Shares the single Sdram_Control FIFO port pair between two requesters (0 = VGA line fetch, 1 = game/tile writer).

---
 rtl/sdram_port_scheduler_pkg.sv | 21 ++
 rtl/sdram_port_scheduler_rr_arb.sv | 31 +++
 rtl/sdram_port_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_sdram_port_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_scheduler_pkg.sv
// Shared state encoding, default burst/timing limits and small helpers
// for the two-requester SDRAM FIFO-port scheduler.
package sdram_port_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WR_STREAM = 3'd2,
    ST_RD_STREAM = 3'd3,
    ST_FIN       = 3'd4
  } sched_state_t;

  localparam int DEF_MAX_LEN  = 256;
  localparam int DEF_LOAD_CYC = 4;
  localparam int DEF_TIMEOUT  = 1023;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_port_scheduler_rr_arb.sv
// Two-input round-robin arbiter; the last-served pointer only moves when
// the caller accepts the grant, so a stalled grant keeps its priority.
module sdram_port_scheduler_rr_arb
  import sdram_port_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_q;

  // Reset to "requester 1 served last" so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant[1];
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Shares the Sdram_Control write/read FIFO ports between two requesters:
// arbitrates bursts, sequences LOAD pulses and FIFO strobes, reports DONE/ERR.
module sdram_port_scheduler
  import sdram_port_scheduler_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int LEN_W    = 9,
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int LOAD_CYC = DEF_LOAD_CYC,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*LEN_W-1:0]  req_len,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic [1:0]          wdata_valid,
  output logic [1:0]          wdata_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rdata_valid,
  output logic [1:0]          done,
  output logic [1:0]          err,
  output logic [DATA_W-1:0]   wr_data,
  output logic                wr,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [LEN_W-1:0]    wr_length,
  output logic                wr_load,
  input  logic                wr_full,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic [LEN_W-1:0]    rd_length,
  output logic                rd_load,
  output logic                rd,
  input  logic                rd_empty,
  input  logic [DATA_W-1:0]   rd_data
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int LC_W = $clog2(LOAD_CYC + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [TO_W-1:0]  TIMEOUT_V = TO_W'(TIMEOUT);
  localparam logic [LC_W-1:0]  LOAD_LAST = LC_W'(LOAD_CYC - 1);

  sched_state_t state_q, state_d;

  logic              g_q;
  logic              dir_q;
  logic              err_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [TO_W-1:0]   idle_q;
  logic [LC_W-1:0]   load_q;
  logic [1:0]        rd_valid_q;

  logic [1:0]        arb_req;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              sel_write;
  logic              len_ok;
  logic [DATA_W-1:0] wdata_sel;
  logic              timeout;
  logic              wr_go;
  logic              rd_go;
  logic              last_word;

  assign arb_req = (state_q == ST_IDLE) ? req_valid : 2'b00;

  sdram_port_scheduler_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (arb_req),
    .accept  (|grant),
    .grant   (grant)
  );

  always_comb begin
    sel_addr  = grant[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_len   = grant[1] ? req_len[2*LEN_W-1:LEN_W]   : req_len[LEN_W-1:0];
    sel_write = grant[1] ? req_write[1]               : req_write[0];
    len_ok    = (sel_len != '0) && (sel_len <= MAX_LEN_V);
    wdata_sel = g_q ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
  end

  // The idle counter only runs in the stream states; once it hits the limit
  // every strobe is suppressed so the burst ends cleanly in FIN.
  always_comb begin
    timeout   = ((state_q == ST_WR_STREAM) || (state_q == ST_RD_STREAM)) &&
                (idle_q == TIMEOUT_V);
    wr_go     = (state_q == ST_WR_STREAM) && !timeout && !wr_full && wdata_valid[g_q];
    rd_go     = (state_q == ST_RD_STREAM) && !timeout && !rd_empty;
    last_word = (wr_go || rd_go) && ((cnt_q + LEN_W'(1)) == len_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = len_ok ? ST_LOAD : ST_FIN;
        end
      end
      ST_LOAD: begin
        if (load_q == LOAD_LAST) begin
          state_d = dir_q ? ST_WR_STREAM : ST_RD_STREAM;
        end
      end
      ST_WR_STREAM, ST_RD_STREAM: begin
        if (timeout || last_word) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst context is captured at grant time; zero/oversize bursts skip
  // the address registers so the controller never sees them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_q        <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      load_q     <= '0;
      rd_valid_q <= '0;
      wr_addr    <= '0;
      wr_length  <= '0;
      rd_addr    <= '0;
      rd_length  <= '0;
    end else begin
      rd_valid_q <= rd_go ? port_onehot(g_q) : 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            g_q    <= grant[1];
            dir_q  <= sel_write;
            len_q  <= sel_len;
            err_q  <= (sel_len > MAX_LEN_V);
            cnt_q  <= '0;
            idle_q <= '0;
            load_q <= '0;
            if (len_ok && sel_write) begin
              wr_addr   <= sel_addr;
              wr_length <= sel_len;
            end
            if (len_ok && !sel_write) begin
              rd_addr   <= sel_addr;
              rd_length <= sel_len;
            end
          end
        end
        ST_LOAD: load_q <= load_q + LC_W'(1);
        ST_WR_STREAM, ST_RD_STREAM: begin
          if (wr_go || rd_go) begin
            cnt_q  <= cnt_q + LEN_W'(1);
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + TO_W'(1);
          end
          if (timeout) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The read FIFO is not show-ahead, so read data is qualified by the
  // registered copy of the previous cycle's pop.
  always_comb begin
    req_ready   = grant;
    wdata_ready = 2'b00;
    if ((state_q == ST_WR_STREAM) && !wr_full && !timeout) begin
      wdata_ready = port_onehot(g_q);
    end
    wr          = wr_go;
    rd          = rd_go;
    wr_data     = (state_q == ST_WR_STREAM) ? wdata_sel : '0;
    wr_load     = (state_q == ST_LOAD) && dir_q;
    rd_load     = (state_q == ST_LOAD) && !dir_q;
    done        = 2'b00;
    err         = 2'b00;
    if (state_q == ST_FIN) begin
      if (err_q) begin
        err = port_onehot(g_q);
      end else begin
        done = port_onehot(g_q);
      end
    end
    rdata_valid = rd_valid_q;
    rdata       = (|rd_valid_q) ? rd_data : '0;
  end

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed bench for sdram_port_scheduler: write/read bursts, round-robin,
// back-pressure, length corner cases, timeout and mid-burst reset.
module tb_sdram_port_scheduler;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 16;
  localparam int LEN_W    = 9;
  localparam int MAX_LEN  = 256;
  localparam int LOAD_CYC = 4;
  localparam int TIMEOUT  = 1023;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*LEN_W-1:0]  req_len;
  logic [2*DATA_W-1:0] wdata;
  logic [1:0]          wdata_valid;
  logic [1:0]          wdata_ready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rdata_valid;
  logic [1:0]          done;
  logic [1:0]          err;
  logic [DATA_W-1:0]   wr_data;
  logic                wr;
  logic [ADDR_W-1:0]   wr_addr;
  logic [LEN_W-1:0]    wr_length;
  logic                wr_load;
  logic                wr_full;
  logic [ADDR_W-1:0]   rd_addr;
  logic [LEN_W-1:0]    rd_length;
  logic                rd_load;
  logic                rd;
  logic                rd_empty;
  logic [DATA_W-1:0]   rd_data = '0;

  logic model_clear;
  logic empty_stuck;
  int   rd_fill;
  int   rd_ptr = 0;

  int checks   = 0;
  int failures = 0;

  int          words, load_n, done_n, bad, v, full_n, rdn, cyc, gn, both_n, done_c, last_c;
  logic [15:0] got [16];
  logic [1:0]  gl [4];
  logic [1:0]  exp_g [4];
  logic [1:0]  done_val;
  logic        prev_rd;
  logic        found;

  sdram_port_scheduler #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LEN_W    (LEN_W),
    .MAX_LEN  (MAX_LEN),
    .LOAD_CYC (LOAD_CYC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .err         (err),
    .wr_data     (wr_data),
    .wr          (wr),
    .wr_addr     (wr_addr),
    .wr_length   (wr_length),
    .wr_load     (wr_load),
    .wr_full     (wr_full),
    .rd_addr     (rd_addr),
    .rd_length   (rd_length),
    .rd_load     (rd_load),
    .rd          (rd),
    .rd_empty    (rd_empty),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  // Non-show-ahead read FIFO model holding 0xA1, 0xA2, ... in order.
  always @(posedge clk) begin
    if (model_clear) begin
      rd_ptr <= 0;
    end else if (rd) begin
      rd_data <= 16'(16'hA1 + rd_ptr);
      rd_ptr  <= rd_ptr + 1;
    end
  end

  assign rd_empty = empty_stuck || (rd_ptr >= rd_fill);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int who, input logic write,
                                input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    req_valid[who]                 = 1'b1;
    req_write[who]                 = write;
    req_addr[who*ADDR_W +: ADDR_W] = addr;
    req_len[who*LEN_W +: LEN_W]    = len;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    req_len     = '0;
    wdata       = '0;
    wdata_valid = '0;
    wr_full     = 1'b0;
    model_clear = 1'b1;
    empty_stuck = 1'b0;
    rd_fill     = 0;
    exp_g       = '{2'b01, 2'b10, 2'b01, 2'b10};

    #12;
    check_output("reset_outputs_zero",
                 {req_ready, wdata_ready, rdata, rdata_valid, done, err, wr_data, wr, wr_addr,
                  wr_length, wr_load, rd_addr, rd_length, rd_load, rd}, 128'd0);
    step();
    model_clear = 1'b0;
    reset_n     = 1'b1;
    step();

    $display("[TB] requester 1 write burst, addr 0x40 len 4");
    apply_stimulus(1, 1'b1, 25'h40, 9'd4);
    wdata_valid = 2'b10;
    wdata[2*DATA_W-1:DATA_W] = 16'hA1;
    #1 check_output("wr_grant", req_ready, 2'b10);
    step();
    req_valid = '0;
    words = 0; load_n = 0; done_n = 0; bad = 0; done_val = '0;
    for (int c = 0; c < 14; c++) begin
      wdata[2*DATA_W-1:DATA_W] = 16'(16'hA1 + words);
      wdata_valid[1] = (words < 4);
      #1;
      if (wr_load) load_n++;
      if (rd_load || rd || wdata_ready[0] || rdata_valid != 2'b00 || err != 2'b00) bad++;
      if (wr) begin
        if (words < 16) got[words] = wr_data;
        words++;
      end
      if (done != 2'b00) begin
        done_n++;
        done_val = done;
      end
      step();
    end
    wdata_valid = '0;
    check_output("wr_load_cycles", load_n, LOAD_CYC);
    check_output("wr_word_count", words, 4);
    for (int i = 0; i < 4; i++) check_output("wr_data_word", got[i], 16'(16'hA1 + i));
    check_output("wr_done_count", done_n, 1);
    check_output("wr_done_port", done_val, 2'b10);
    check_output("wr_addr_reg", wr_addr, 25'h40);
    check_output("wr_length_reg", wr_length, 9'd4);
    check_output("wr_other_side_quiet", bad, 0);

    $display("[TB] requester 0 read burst, addr 0x40 len 4");
    model_clear = 1'b1;
    rd_fill     = 4;
    step();
    model_clear = 1'b0;
    apply_stimulus(0, 1'b0, 25'h40, 9'd4);
    #1 check_output("rd_grant", req_ready, 2'b01);
    step();
    req_valid = '0;
    load_n = 0; rdn = 0; v = 0; bad = 0; done_n = 0; done_c = -1; last_c = -2; prev_rd = 1'b0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (rd_load) load_n++;
      if (rd) rdn++;
      if (rdata_valid[0]) begin
        if (!prev_rd) bad++;
        if (v < 16) got[v] = rdata;
        v++;
        last_c = c;
      end
      if (rdata_valid[1] || wr || wr_load || done[1] || err != 2'b00) bad++;
      if (done[0]) begin
        done_n++;
        done_c = c;
      end
      prev_rd = rd;
      step();
    end
    check_output("rd_load_cycles", load_n, LOAD_CYC);
    check_output("rd_pop_count", rdn, 4);
    check_output("rd_valid_count", v, 4);
    for (int i = 0; i < 4; i++) check_output("rd_data_word", got[i], 16'(16'hA1 + i));
    check_output("rd_valid_timing", bad, 0);
    check_output("rd_done_count", done_n, 1);
    check_output("rd_done_with_last", done_c, last_c);
    check_output("rd_addr_reg", rd_addr, 25'h40);
    check_output("rd_length_reg", rd_length, 9'd4);

    $display("[TB] zero-length and oversize bursts");
    req_write = '0;
    apply_stimulus(0, 1'b0, 25'h10, 9'd0);
    #1 check_output("len0_grant", req_ready, 2'b01);
    step();
    req_valid = '0;
    #1 check_output("len0_done", {done, err, wr_load, rd_load}, {2'b01, 2'b00, 1'b0, 1'b0});
    step();
    check_output("len0_single_pulse", done, 2'b00);
    apply_stimulus(1, 1'b0, 25'h20, 9'd300);
    #1 check_output("len300_grant", req_ready, 2'b10);
    step();
    req_valid = '0;
    #1 check_output("len300_err", {err, done, wr_load, rd_load}, {2'b10, 2'b00, 1'b0, 1'b0});
    step();
    check_output("len300_single_pulse", err, 2'b00);

    $display("[TB] write burst with WR_FULL asserted for three cycles");
    apply_stimulus(1, 1'b1, 25'h80, 9'd4);
    wdata_valid = 2'b10;
    wdata[2*DATA_W-1:DATA_W] = 16'hB1;
    #1 check_output("full_grant", req_ready, 2'b10);
    step();
    req_valid = '0;
    words = 0; full_n = 0; bad = 0; done_n = 0;
    for (int c = 0; c < 20; c++) begin
      wdata[2*DATA_W-1:DATA_W] = 16'(16'hB1 + words);
      wdata_valid[1] = (words < 4);
      wr_full = (words == 2) && (full_n < 3);
      #1;
      if (wr_full) begin
        full_n++;
        if (wr || wdata_ready[1]) bad++;
      end
      if (wr) begin
        if (words < 16) got[words] = wr_data;
        words++;
      end
      if (done[1]) done_n++;
      step();
    end
    wr_full     = 1'b0;
    wdata_valid = '0;
    check_output("full_cycles_seen", full_n, 3);
    check_output("full_no_strobe", bad, 0);
    check_output("full_word_count", words, 4);
    for (int i = 0; i < 4; i++) check_output("full_data_word", got[i], 16'(16'hB1 + i));
    check_output("full_done_count", done_n, 1);

    $display("[TB] read with RD_EMPTY stuck high");
    empty_stuck = 1'b1;
    apply_stimulus(0, 1'b0, 25'h100, 9'd4);
    #1 check_output("to_grant", req_ready, 2'b01);
    step();
    req_valid = '0;
    rdn = 0; found = 1'b0; cyc = 0; done_val = '0; done_c = -1;
    while (!found && cyc < 1200) begin
      #1;
      if (rd) rdn++;
      if (err != 2'b00 || done != 2'b00) begin
        found    = 1'b1;
        done_val = err;
        done_c   = cyc;
      end
      step();
      cyc++;
    end
    empty_stuck = 1'b0;
    check_output("to_fired", found, 1'b1);
    check_output("to_err_port", done_val, 2'b01);
    check_output("to_no_pops", rdn, 0);
    check_output("to_latency_window",
                 (done_c >= TIMEOUT + LOAD_CYC - 1) && (done_c <= TIMEOUT + LOAD_CYC + 3), 1'b1);

    $display("[TB] reset asserted during WR_STREAM");
    apply_stimulus(1, 1'b1, 25'h1C0, 9'd4);
    wdata_valid = '0;
    #1 check_output("rst_grant", req_ready, 2'b10);
    step();
    req_valid = '0;
    repeat (LOAD_CYC) step();
    check_output("rst_in_stream", wdata_ready, 2'b10);
    reset_n = 1'b0;
    #1;
    check_output("rst_outputs_zero",
                 {req_ready, wdata_ready, rdata, rdata_valid, done, err, wr_data, wr, wr_addr,
                  wr_length, wr_load, rd_addr, rd_length, rd_load, rd}, 128'd0);
    step();
    step();
    reset_n = 1'b1;

    $display("[TB] both requesters valid, alternating grants");
    req_write = '0;
    req_len   = '0;
    req_valid = 2'b11;
    gn = 0; both_n = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready == 2'b11) both_n++;
      if (req_ready != 2'b00 && gn < 4) begin
        gl[gn] = req_ready;
        gn++;
      end
      step();
    end
    req_valid = '0;
    check_output("rr_grant_count", gn, 4);
    for (int i = 0; i < 4; i++) check_output("rr_grant_order", gl[i], exp_g[i]);
    check_output("rr_never_both", both_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
